// File: rtl/rx_frame_generator.sv
// ---------------------------------------------------------------------------
// rx_frame_generator
//
// Stands in for the transceiver receive outputs so that the downstream reorder
// buffer and DRAM writer can run without transceivers. Emits, on NUM_CH
// parallel lanes, a repeating stream of
//   header, timestamp, PAYLOAD_LEN counting words, ender, zero gap.
//
// Ports
//   clk_trans        : sole clock, rising edge
//   rst_n            : synchronous active-low reset
//   run_en           : start / keep generating (sampled in IDLE and at ENDER)
//   ch_en            : lane enable mask, captured at every header
//   pkt_limit        : frames per run, 0 = unlimited (captured on leaving IDLE)
//   err_inject       : pulse that arms corruption of lane 0 on the next ender
//   rx_parallel_data : lane c on bits [c*DATA_W +: DATA_W]
//   rx_sop / rx_eop  : header / ender word on the outputs
//   busy             : generator active
//   done             : one-cycle pulse with the final ender of a run
//   frame_count      : frames completed since the run started (wraps)
// ---------------------------------------------------------------------------
module rx_frame_generator #(
  parameter int          NUM_CH         = 8,
  parameter int          DATA_W         = 16,
  parameter int          PAYLOAD_LEN    = 125,
  parameter logic [15:0] HEADER_WORD    = 16'hDEAD,
  parameter logic [15:0] ENDER_WORD     = 16'hBEEF,
  parameter int          TS_INIT        = 10,
  parameter int          SHORT_GAP      = 22,
  parameter int          LONG_GAP       = 2002,
  parameter int          LONG_GAP_AFTER = 16
) (
  input  logic                     clk_trans,
  input  logic                     rst_n,
  input  logic                     run_en,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [15:0]              pkt_limit,
  input  logic                     err_inject,
  output logic [NUM_CH*DATA_W-1:0] rx_parallel_data,
  output logic                     rx_sop,
  output logic                     rx_eop,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              frame_count
);

  localparam int HALF_W  = DATA_W / 2;
  localparam int GAP_MAX = (LONG_GAP > SHORT_GAP) ? LONG_GAP : SHORT_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [HALF_W-1:0] CNT_LAST   = HALF_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0]  SHORT_LAST = GAP_W'(SHORT_GAP - 1);
  localparam logic [GAP_W-1:0]  LONG_LAST  = GAP_W'(LONG_GAP - 1);
  localparam logic [15:0]       SAT_MAX    = 16'(LONG_GAP_AFTER);
  localparam logic [DATA_W-1:0] HDR_W      = DATA_W'(HEADER_WORD);
  localparam logic [DATA_W-1:0] END_W      = DATA_W'(ENDER_WORD);
  localparam logic [DATA_W-1:0] TS0_W      = DATA_W'(TS_INIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_TS      = 3'd2,
    S_PAYLOAD = 3'd3,
    S_ENDER   = 3'd4,
    S_GAP     = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_W-1:0]         ts_q, ts_d;
  logic [HALF_W-1:0]         iter_q, iter_d;
  logic [HALF_W-1:0]         cnt_q, cnt_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [15:0]               fc_q, fc_d;
  logic [15:0]               sat_q, sat_d;
  logic [15:0]               limit_q, limit_d;
  logic [NUM_CH-1:0]         ch_en_q, ch_en_d;
  logic                      arm_q, arm_d;
  logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
  logic                      sop_q, sop_d;
  logic                      eop_q, eop_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [DATA_W-1:0]         word_s;
  logic [NUM_CH-1:0]         lane_mask_s;
  logic                      corrupt_s;
  logic [15:0]               fc_inc_s;
  logic [15:0]               sat_inc_s;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q;
    iter_d      = iter_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    fc_d        = fc_q;
    sat_d       = sat_q;
    limit_d     = limit_q;
    ch_en_d     = ch_en_q;
    arm_d       = arm_q | err_inject;
    data_d      = '0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    done_d      = 1'b0;
    word_s      = '0;
    lane_mask_s = ch_en_q;
    corrupt_s   = 1'b0;
    // Output registers lag the state by one edge, so busy follows state_q.
    busy_d      = (state_q != S_IDLE);
    fc_inc_s    = fc_q + 16'd1;
    sat_inc_s   = (sat_q < SAT_MAX) ? (sat_q + 16'd1) : sat_q;

    case (state_q)
      S_IDLE: begin
        if (run_en) begin
          limit_d = pkt_limit;
          fc_d    = '0;
          sat_d   = '0;
          state_d = S_HEADER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HEADER: begin
        // The newly captured mask already governs the header word itself.
        word_s      = HDR_W;
        sop_d       = 1'b1;
        ch_en_d     = ch_en;
        lane_mask_s = ch_en;
        state_d     = S_TS;
      end
      S_TS: begin
        word_s  = ts_q;
        ts_d    = ts_q + DATA_W'(1);
        state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        word_s = {iter_q, cnt_q};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_ENDER;
        end else begin
          cnt_d   = cnt_q + HALF_W'(1);
          state_d = S_PAYLOAD;
        end
      end
      S_ENDER: begin
        word_s    = END_W;
        eop_d     = 1'b1;
        corrupt_s = arm_q;
        // The old arm is consumed here; a pulse in this same cycle re-arms
        // for the following frame.
        arm_d     = err_inject;
        iter_d    = iter_q + HALF_W'(1);
        fc_d      = fc_inc_s;
        sat_d     = sat_inc_s;
        if (((limit_q != 16'd0) && (fc_inc_s == limit_q)) || !run_en) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d   = (sat_inc_s < SAT_MAX) ? SHORT_LAST : LONG_LAST;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_HEADER;
        end else begin
          gap_d   = gap_q - GAP_W'(1);
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    for (int c = 0; c < NUM_CH; c++) begin
      if (lane_mask_s[c]) begin
        if ((c == 0) && corrupt_s) begin
          data_d[c*DATA_W +: DATA_W] = ~word_s;
        end else begin
          data_d[c*DATA_W +: DATA_W] = word_s;
        end
      end else begin
        data_d[c*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk_trans) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ts_q    <= TS0_W;
      iter_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      fc_q    <= '0;
      sat_q   <= '0;
      limit_q <= '0;
      ch_en_q <= '0;
      arm_q   <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      fc_q    <= fc_d;
      sat_q   <= sat_d;
      limit_q <= limit_d;
      ch_en_q <= ch_en_d;
      arm_q   <= arm_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rx_parallel_data = data_q;
  assign rx_sop           = sop_q;
  assign rx_eop           = eop_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign frame_count      = fc_q;

endmodule
